// File: rtl/xbar_pkt_sched_pkg.sv
// Shared types and helpers for the packet-aware crossbar grant scheduler:
// index-width helpers, per-output state record and the rotating-priority search.
package xbar_pkt_sched_pkg;

    // Internal index width; bounds the largest supported requester count.
    localparam int MAX_IN_W = 6;
    localparam int MAX_IN   = 1 << MAX_IN_W;

    function automatic int log2up(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                lock;
        logic [MAX_IN_W-1:0] owner;
        logic [MAX_IN_W-1:0] last;
    } slice_state_t;

    // First set bit of cand scanning upward from last+1, wrapping at n.
    // Returns 0 when nothing is set; callers qualify with |cand.
    function automatic logic [MAX_IN_W-1:0] rr_first(
        input logic [MAX_IN-1:0]   cand,
        input logic [MAX_IN_W:0]   n,
        input logic [MAX_IN_W-1:0] last
    );
        logic [MAX_IN_W-1:0] pick;
        logic                found;
        logic [MAX_IN_W+1:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_IN; k++) begin
            idx = {2'b00, last} + (MAX_IN_W+2)'(k);
            if (idx >= {1'b0, n}) begin
                idx = idx - {1'b0, n};
            end
            if (!found && ((MAX_IN_W+1)'(k) <= n) && cand[idx[MAX_IN_W-1:0]]) begin
                pick  = idx[MAX_IN_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/xbar_pkt_sched_slice.sv
// One output port of the scheduler: round-robin pick while idle, packet lock
// on the owner until its end-of-packet beat transfers.
module xbar_pkt_sched_slice
    import xbar_pkt_sched_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int IN_WIDTH    = log2up(NUM_INPUTS),
    parameter bit LOCK_ENABLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] cand,
    input  logic [NUM_INPUTS-1:0] eop,
    input  logic                  out_ready,
    output logic                  grant_valid,
    output logic [IN_WIDTH-1:0]   grant_idx,
    output logic                  locked,
    output logic                  fire,
    output logic                  collide
);

    slice_state_t        state_q, state_d;
    logic [MAX_IN-1:0]   cand_full, eop_full;
    logic [MAX_IN_W-1:0] rr_pick, gidx_full;
    logic                gv;

    always_comb begin
        cand_full = MAX_IN'(cand);
        eop_full  = MAX_IN'(eop);
        rr_pick   = rr_first(cand_full, (MAX_IN_W+1)'(NUM_INPUTS), state_q.last);

        if (state_q.lock) begin
            gv        = cand_full[state_q.owner];
            gidx_full = state_q.owner;
        end else begin
            gv        = |cand;
            gidx_full = rr_pick;
        end
        // Outputs read as idle for as long as reset is held.
        if (!reset) begin
            gv        = 1'b0;
            gidx_full = '0;
        end

        fire    = gv && out_ready;
        collide = fire && (|(cand & (cand - NUM_INPUTS'(1))));

        state_d = state_q;
        if (fire) begin
            state_d.last = gidx_full;
            if (LOCK_ENABLE && !eop_full[gidx_full]) begin
                state_d.lock  = 1'b1;
                state_d.owner = gidx_full;
            end else begin
                state_d.lock  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '{lock: 1'b0, owner: '0, last: MAX_IN_W'(NUM_INPUTS - 1)};
        end else begin
            state_q <= state_d;
        end
    end

    assign grant_valid = gv;
    assign grant_idx   = IN_WIDTH'(gidx_full);
    assign locked      = state_q.lock;

endmodule

// File: rtl/xbar_pkt_sched.sv
// Packet-aware grant scheduler for the stream crossbar: decodes candidates per
// output, fans ready back to the requesters and counts contended grants.
module xbar_pkt_sched
    import xbar_pkt_sched_pkg::*;
#(
    parameter int NUM_INPUTS    = 4,
    parameter int NUM_OUTPUTS   = 4,
    parameter int IN_WIDTH      = log2up(NUM_INPUTS),
    parameter int OUT_WIDTH     = log2up(NUM_OUTPUTS),
    parameter bit LOCK_ENABLE   = 1'b1,
    parameter int PERF_CTR_BITS = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_INPUTS-1:0]                 req_valid,
    input  logic [NUM_INPUTS-1:0][OUT_WIDTH-1:0]  req_sel,
    input  logic [NUM_INPUTS-1:0]                 req_eop,
    output logic [NUM_INPUTS-1:0]                 req_ready,
    output logic [NUM_OUTPUTS-1:0]                grant_valid,
    output logic [NUM_OUTPUTS-1:0][IN_WIDTH-1:0]  grant_idx,
    input  logic [NUM_OUTPUTS-1:0]                out_ready,
    output logic [NUM_OUTPUTS-1:0]                locked,
    output logic [PERF_CTR_BITS-1:0]              collisions
);

    localparam int OUT_PAD = 1 << OUT_WIDTH;
    localparam int IN_PAD  = 1 << IN_WIDTH;

    logic [NUM_INPUTS-1:0][OUT_WIDTH-1:0]  dest;
    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] cand;
    logic [NUM_OUTPUTS-1:0]                fire, collide;
    logic [OUT_PAD-1:0]                    fire_pad;
    logic [OUT_PAD-1:0][IN_WIDTH-1:0]      gidx_pad;
    logic [IN_PAD-1:0]                     valid_pad;
    logic [IN_PAD-1:0][OUT_WIDTH-1:0]      dest_pad;
    logic [PERF_CTR_BITS-1:0]              collisions_q, collisions_d;

    genvar gi, go;

    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_dest
            assign dest[gi] = (NUM_OUTPUTS == 1) ? '0 : req_sel[gi];
        end

        for (go = 0; go < NUM_OUTPUTS; go++) begin : g_out
            for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_cand
                assign cand[go][gi] = req_valid[gi] && (dest[gi] == OUT_WIDTH'(go));
            end

            xbar_pkt_sched_slice #(
                .NUM_INPUTS (NUM_INPUTS),
                .IN_WIDTH   (IN_WIDTH),
                .LOCK_ENABLE(LOCK_ENABLE)
            ) u_slice (
                .clk        (clk),
                .reset      (reset),
                .cand       (cand[go]),
                .eop        (req_eop),
                .out_ready  (out_ready[go]),
                .grant_valid(grant_valid[go]),
                .grant_idx  (grant_idx[go]),
                .locked     (locked[go]),
                .fire       (fire[go]),
                .collide    (collide[go])
            );

            // The owner must keep its destination until its packet ends.
            logic owner_moved;
            assign owner_moved = locked[go] && valid_pad[grant_idx[go]]
                                 && (dest_pad[grant_idx[go]] != OUT_WIDTH'(go));
            owner_keeps_sel: assert property (@(posedge clk) disable iff (!reset) !owner_moved);
        end
    endgenerate

    always_comb begin
        fire_pad                     = '0;
        fire_pad[NUM_OUTPUTS-1:0]    = fire;
        gidx_pad                     = '0;
        gidx_pad[NUM_OUTPUTS-1:0]    = grant_idx;
        valid_pad                    = '0;
        valid_pad[NUM_INPUTS-1:0]    = req_valid;
        dest_pad                     = '0;
        dest_pad[NUM_INPUTS-1:0]     = dest;
        req_ready                    = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            req_ready[i] = fire_pad[dest[i]] && (gidx_pad[dest[i]] == IN_WIDTH'(i));
        end
    end

    always_comb begin
        collisions_d = collisions_q;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            collisions_d = collisions_d + PERF_CTR_BITS'(collide[o]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            collisions_q <= '0;
        end else begin
            collisions_q <= collisions_d;
        end
    end

    assign collisions = collisions_q;

endmodule

// File: tb/tb_xbar_pkt_sched.sv
// Scoreboard bench for xbar_pkt_sched: a packet-level reference model queues the
// expected per-cycle response and an independent monitor compares the DUT.
module tb_xbar_pkt_sched;

    localparam bit LOCK = 1'b1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3:0]      req_valid = '0, req_eop = '0, out_ready = '0;
    logic [3:0][1:0] req_sel = '0;
    logic [3:0]      req_ready, grant_valid, locked;
    logic [3:0][1:0] grant_idx;
    logic [31:0]     collisions;

    logic [3:0]      nl_req_valid = '0, nl_req_eop = '0, nl_out_ready = '0;
    logic [3:0][1:0] nl_req_sel = '0;
    logic [3:0]      nl_req_ready, nl_grant_valid, nl_locked;
    logic [3:0][1:0] nl_grant_idx;
    logic [31:0]     nl_collisions;

    always #5 clk = ~clk;

    xbar_pkt_sched #(.NUM_INPUTS(4), .NUM_OUTPUTS(4), .LOCK_ENABLE(1'b1), .PERF_CTR_BITS(32)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_sel(req_sel), .req_eop(req_eop),
        .req_ready(req_ready), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .out_ready(out_ready), .locked(locked), .collisions(collisions)
    );

    xbar_pkt_sched #(.NUM_INPUTS(4), .NUM_OUTPUTS(4), .LOCK_ENABLE(1'b0), .PERF_CTR_BITS(32)) u_dut_nl (
        .clk(clk), .reset(reset), .req_valid(nl_req_valid), .req_sel(nl_req_sel), .req_eop(nl_req_eop),
        .req_ready(nl_req_ready), .grant_valid(nl_grant_valid), .grant_idx(nl_grant_idx),
        .out_ready(nl_out_ready), .locked(nl_locked), .collisions(nl_collisions)
    );

    typedef struct packed {
        logic            rst;
        logic [3:0]      rdy;
        logic [3:0]      gv;
        logic [3:0]      lk;
        logic [3:0][1:0] gi;
        logic [31:0]     coll;
    } exp_t;

    exp_t scb[$];
    int   nlq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: per output, owner (-1 when free) and last winner.
    int          m_owner[4];
    int          m_last[4];
    logic [31:0] m_coll;
    logic [3:0]  m_rdy;
    logic        rst_lvl = 1'b1;

    // Directed/random packet driver: beats left and destination per input.
    int          drem[4];
    logic [1:0]  ddst[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0][1:0] sel,
                        input logic [3:0] eop, input logic [3:0] ordy);
        exp_t e;
        int   w, n, idx;
        @(negedge clk);
        reset     = rst_lvl;
        req_valid = v;
        req_sel   = sel;
        req_eop   = eop;
        out_ready = ordy;
        #1;
        e     = '0;
        m_rdy = '0;
        if (!rst_lvl) begin
            e.rst = 1'b1;
            for (int o = 0; o < 4; o++) begin
                m_owner[o] = -1;
                m_last[o]  = 3;
            end
            m_coll = '0;
        end else begin
            e.coll = m_coll;
            for (int o = 0; o < 4; o++) begin
                n = 0;
                w = -1;
                for (int i = 0; i < 4; i++) begin
                    if (v[i] && int'(sel[i]) == o) n++;
                end
                e.lk[o] = (m_owner[o] >= 0);
                if (m_owner[o] >= 0) begin
                    if (v[m_owner[o]] && int'(sel[m_owner[o]]) == o) w = m_owner[o];
                end else begin
                    for (int k = 1; k <= 4; k++) begin
                        idx = (m_last[o] + k) % 4;
                        if (w < 0 && v[idx] && int'(sel[idx]) == o) w = idx;
                    end
                end
                if (w >= 0) begin
                    e.gv[o] = 1'b1;
                    e.gi[o] = 2'(w);
                    if (ordy[o]) begin
                        m_rdy[w] = 1'b1;
                        if (n > 1) m_coll = m_coll + 32'd1;
                        m_last[o]  = w;
                        m_owner[o] = (LOCK && !eop[w]) ? w : -1;
                    end
                end
            end
        end
        e.rdy = m_rdy;
        scb.push_back(e);
    endtask

    task automatic step_pkts(input logic [3:0] ordy, input logic [3:0] hold);
        logic [3:0]      v, eop;
        logic [3:0][1:0] sel;
        for (int i = 0; i < 4; i++) begin
            v[i]   = (drem[i] > 0) && !hold[i];
            eop[i] = (drem[i] == 1);
            sel[i] = ddst[i];
        end
        step(v, sel, eop, ordy);
        for (int i = 0; i < 4; i++) begin
            if (m_rdy[i]) drem[i] = drem[i] - 1;
        end
    endtask

    task automatic drive_pkts(input int maxcyc);
        int c = 0;
        while (((drem[0] | drem[1] | drem[2] | drem[3]) != 0) && c < maxcyc) begin
            step_pkts(4'hF, 4'h0);
            c++;
        end
        chk("drain_timeout", 32'(drem[0] + drem[1] + drem[2] + drem[3]), 32'd0);
    endtask

    // Monitor: one expected record per cycle, compared after inputs settle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (scb.size() != 0) begin
                e = scb.pop_front();
                chk("req_ready", 32'(req_ready), 32'(e.rdy));
                chk("grant_valid", 32'(grant_valid), 32'(e.gv));
                chk("locked", 32'(locked), 32'(e.lk));
                chk("collisions", collisions, e.coll);
                for (int o = 0; o < 4; o++) begin
                    if (e.gv[o] || e.rst) chk($sformatf("grant_idx[%0d]", o), 32'(grant_idx[o]), 32'(e.gi[o]));
                end
            end
        end
    end

    // Monitor for the no-lock instance: checks each fire at output 0.
    initial begin
        int x;
        forever begin
            @(negedge clk);
            #2;
            if (nl_grant_valid[0] && nl_out_ready[0]) begin
                if (nlq.size() == 0) begin
                    chk("nl_unexpected_fire", 32'(nl_grant_idx[0]), 32'hFFFF_FFFF);
                end else begin
                    x = nlq.pop_front();
                    chk("nl_grant_idx", 32'(nl_grant_idx[0]), 32'(x));
                    chk("nl_req_ready", 32'(nl_req_ready), 32'(4'b0001 << x));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            drem[i] = 0;
            ddst[i] = '0;
        end

        // Reset held with traffic present: nothing granted.
        rst_lvl = 1'b0;
        drem[0] = 1; ddst[0] = 2'd1;
        step_pkts(4'hF, 4'h0);
        step_pkts(4'hF, 4'h0);
        rst_lvl = 1'b1;
        drem[0] = 0;

        // Reset mid-packet: input 1 locks output 2, reset drops after beat 1.
        drem[1] = 3; ddst[1] = 2'd2;
        step_pkts(4'hF, 4'h0);
        rst_lvl = 1'b0;
        step_pkts(4'hF, 4'h0);
        rst_lvl = 1'b1;
        drem[0] = 1; ddst[0] = 2'd2;
        drem[1] = 1; ddst[1] = 2'd2;
        drive_pkts(10);

        // Lock hold: input 0 streams 4 beats to output 1 while input 3 waits.
        drem[0] = 4; ddst[0] = 2'd1;
        drem[3] = 1; ddst[3] = 2'd1;
        drive_pkts(20);

        // Backpressure on output 2 mid-packet with a waiting contender.
        drem[2] = 3; ddst[2] = 2'd2;
        drem[1] = 1; ddst[1] = 2'd2;
        step_pkts(4'hF, 4'h0);
        repeat (5) step_pkts(4'b1011, 4'h0);
        drive_pkts(20);

        // Parallel outputs, all single-beat.
        for (int i = 0; i < 4; i++) begin
            drem[i] = 1;
            ddst[i] = 2'(i);
        end
        step_pkts(4'hF, 4'h0);

        // Single-beat packet at output 3, then input 3 should win next.
        drem[2] = 1; ddst[2] = 2'd3;
        step_pkts(4'hF, 4'h0);
        drem[2] = 1; ddst[2] = 2'd3;
        drem[3] = 1; ddst[3] = 2'd3;
        drive_pkts(10);

        // Randomised traffic with gaps and backpressure.
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] ordy, hold;
            for (int i = 0; i < 4; i++) begin
                if (drem[i] == 0 && $urandom_range(1, 0) == 1) begin
                    drem[i] = int'($urandom_range(4, 1));
                    ddst[i] = 2'($urandom_range(3, 0));
                end
                hold[i] = ($urandom_range(3, 0) == 0);
                ordy[i] = ($urandom_range(3, 0) != 0);
            end
            step_pkts(ordy, hold);
        end
        drive_pkts(200);

        // Re-arbitration every beat when locking is disabled.
        @(negedge clk);
        nlq = '{0, 1, 2, 3, 0, 1};
        nl_req_valid = 4'hF;
        nl_req_sel   = '0;
        nl_req_eop   = 4'h0;
        nl_out_ready = 4'h1;
        repeat (6) @(negedge clk);
        nl_req_valid = 4'h0;
        nl_out_ready = 4'h0;

        repeat (3) @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(scb.size()), 32'd0);
        chk("nl_queue_drained", 32'(nlq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
